srpt_fetch_dma_issuer: RTL and testbench
========================================

Name: srpt_fetch_dma_issuer

Overview:
- Consumer end of the SRPT fetch queue.
- Accepts per-cache-block fetch requests from the srpt_queue (TYPE "fetch") master stream and turns each into a host DMA read into the data buffer.
- Tracks outstanding reads by tag and returns dbuff-progress updates on a stream toward the queue's slave input, so the queue learns how much of each message has landed.

Parameters:
- MAX_RPCS, 64, entries in the per-RPC host base-address table.
- MAX_OUTSTANDING, 8, concurrent DMA reads; power of two.
- CACHE_BLOCK_SIZE, 64, bytes per fetch request.
- QUEUE_ENTRY_SIZE, 66, stream width; layout [15:0] rpc_id, [25:16] dbuff_id, [45:26] offset (bytes), [65:46] msg_len (bytes).

Ports:
- ap_clk  in  1  clock
- ap_rst  in  1  reset; synchronous, active-high
- S_AXIS_TVALID  in  1  fetch request valid
- S_AXIS_TREADY  out  1  fetch request accept
- S_AXIS_TDATA  in  QUEUE_ENTRY_SIZE  fetch request
- M_AXIS_TVALID  out  1  progress update valid
- M_AXIS_TREADY  in  1  progress update accept
- M_AXIS_TDATA  out  QUEUE_ENTRY_SIZE  progress update: same layout, offset = bytes fetched after this block
- cfg_we  in  1  address-table write strobe
- cfg_rpc_id  in  log2(MAX_RPCS)  table index
- cfg_addr  in  64  host base address
- dma_req_valid  out  1  DMA read command valid
- dma_req_ready  in  1  DMA read command accept
- dma_req_addr  out  64  host address = base[rpc_id] + offset
- dma_req_len  out  8  bytes, 1..CACHE_BLOCK_SIZE
- dma_req_dbuff  out  30  {dbuff_id, offset} write destination
- dma_req_tag  out  log2(MAX_OUTSTANDING)  read tag
- dma_cpl_valid  in  1  read completion; always accepted
- dma_cpl_tag  in  log2(MAX_OUTSTANDING)  completed tag
- err_count  out  16  saturating count of dropped requests and stray completions

Behaviour:
- Reset state:
  - dma_req_valid=0, M_AXIS_TVALID=0, err_count=0.
  - All tags free; completion FIFO empty.
  - Address table not cleared.
- Reset mid-operation:
  - All in-flight context is discarded.
  - Completions arriving after reset match no busy tag and count as stray.
- Accept and issue:
  - S_AXIS_TREADY = !ap_rst && free tag exists && (!dma_req_valid || dma_req_ready).
  - On S_AXIS handshake the block, in the same cycle:
    - allocates the lowest free tag;
    - computes len = min(CACHE_BLOCK_SIZE, msg_len - offset);
    - writes context {rpc_id, dbuff_id, offset+len, msg_len} to the tag;
    - loads the dma_req_* registers.
  - dma_req_valid rises the next cycle. Latency is 1 cycle from S_AXIS handshake to dma_req_valid.
  - Throughput is 1 request/cycle while dma_req_ready=1 and tags are free.
  - dma_req_* stay stable while valid && !ready.
- Malformed request: if offset >= msg_len, the request is consumed with no tag allocated and no DMA issued, and err_count increments.
- Address arithmetic:
  - 64-bit add, wrap on overflow.
  - Table lookup is combinational on the accept cycle.
  - A cfg_we to the same index in the same cycle is not seen; the old base is used. The new value is visible from the next cycle.
- Completion:
  - dma_cpl_valid with a busy tag pushes that tag's context into the update FIFO (depth MAX_OUTSTANDING).
  - A completion on a free tag is ignored and increments err_count.
  - Completions may arrive in any order. Updates are emitted in completion order.
- Update output:
  - The FIFO head drives M_AXIS_TDATA. TVALID = FIFO non-empty. Data is stable while stalled.
  - The tag is freed only on M_AXIS handshake, so in-flight plus queued updates never exceed MAX_OUTSTANDING and the FIFO cannot overflow.
  - Push and pop in the same cycle are both honoured.
- Full condition: with all tags busy, S_AXIS_TREADY=0 until an M_AXIS handshake frees a tag. The freed tag is allocatable the following cycle.
- err_count saturates at 16'hFFFF.

Test Plan:
- Base for rpc 1 = 0x1000_0000, enqueue {rpc 1, dbuff 0, offset 0, len 10000} into the upstream queue, DMA ready and completing after 3 cycles -> exactly 157 DMA reads, addr 0x1000_0000 + 64k, len 64 for k<156 and len 16 last; 157 updates with final offset 10000.
- dma_req_ready held 0 for 20 cycles -> dma_req_* stable; S_AXIS_TREADY drops after 1 accepted request (register full).
- 8 requests issued, no completions -> 9th stalled with TREADY=0. Complete tag 3 and pop its update -> TREADY=1 next cycle and tag 3 reused.
- Completions in order tags 2,0,1 with M_AXIS_TREADY=0 for 10 cycles -> updates emitted 2,0,1 with no loss.
- Request offset 10000, msg_len 10000 -> no DMA, err_count=1. Then a completion on a free tag 5 -> err_count=2.
- Assert ap_rst with 4 reads outstanding, then complete those 4 tags -> no updates, err_count=4, all tags free.

Source files
------------

// File: rtl/srpt_fetch_dma_issuer_if.sv
`default_nettype none
// ============================================================================
// Module   : srpt_fetch_dma_issuer_if
// Brief    : Fetch-request, progress-update and DMA command/completion bundle
//            for the SRPT fetch DMA issuer.
// Revision : 1.0 - initial release
// ============================================================================
interface srpt_fetch_dma_issuer_if #(
    parameter int QUEUE_ENTRY_SIZE = 66,
    parameter int MAX_OUTSTANDING  = 8
);
    localparam int c_tag_w = $clog2(MAX_OUTSTANDING);

    logic                        S_AXIS_TVALID;
    logic                        S_AXIS_TREADY;
    logic [QUEUE_ENTRY_SIZE-1:0] S_AXIS_TDATA;

    logic                        M_AXIS_TVALID;
    logic                        M_AXIS_TREADY;
    logic [QUEUE_ENTRY_SIZE-1:0] M_AXIS_TDATA;

    logic                        dma_req_valid;
    logic                        dma_req_ready;
    logic [63:0]                 dma_req_addr;
    logic [7:0]                  dma_req_len;
    logic [29:0]                 dma_req_dbuff;
    logic [c_tag_w-1:0]          dma_req_tag;

    logic                        dma_cpl_valid;
    logic [c_tag_w-1:0]          dma_cpl_tag;

    // Issuer side
    modport master (
        input  S_AXIS_TVALID, S_AXIS_TDATA,
        output S_AXIS_TREADY,
        output M_AXIS_TVALID, M_AXIS_TDATA,
        input  M_AXIS_TREADY,
        output dma_req_valid, dma_req_addr, dma_req_len, dma_req_dbuff, dma_req_tag,
        input  dma_req_ready,
        input  dma_cpl_valid, dma_cpl_tag
    );

    // Queue / DMA-engine side
    modport slave (
        output S_AXIS_TVALID, S_AXIS_TDATA,
        input  S_AXIS_TREADY,
        input  M_AXIS_TVALID, M_AXIS_TDATA,
        output M_AXIS_TREADY,
        input  dma_req_valid, dma_req_addr, dma_req_len, dma_req_dbuff, dma_req_tag,
        output dma_req_ready,
        output dma_cpl_valid, dma_cpl_tag
    );
endinterface
`default_nettype wire

// File: rtl/srpt_fetch_dma_issuer.sv
`default_nettype none
// ============================================================================
// Module   : srpt_fetch_dma_issuer
// Brief    : Turns SRPT fetch requests into tagged host DMA reads and returns
//            per-block dbuff progress updates in completion order.
// Revision : 1.0 - initial release
// ============================================================================
module srpt_fetch_dma_issuer #(
    parameter int MAX_RPCS         = 64,
    parameter int MAX_OUTSTANDING  = 8,
    parameter int CACHE_BLOCK_SIZE = 64,
    parameter int QUEUE_ENTRY_SIZE = 66
) (
    input  wire                          ap_clk,
    input  wire                          ap_rst,
    srpt_fetch_dma_issuer_if.master      bus,
    input  wire                          cfg_we,
    input  wire [$clog2(MAX_RPCS)-1:0]   cfg_rpc_id,
    input  wire [63:0]                   cfg_addr,
    output logic [15:0]                  err_count
);
    localparam int c_tag_w = $clog2(MAX_OUTSTANDING);
    localparam int c_rpc_w = $clog2(MAX_RPCS);

    logic [15:0]                 w_in_rpc;
    logic [9:0]                  w_in_dbuff;
    logic [19:0]                 w_in_off;
    logic [19:0]                 w_in_len;
    logic [19:0]                 w_remain;
    logic [7:0]                  w_blk_len;
    logic [19:0]                 w_end_off;
    logic [63:0]                 w_base;

    logic [63:0]                 r_addr_tbl [MAX_RPCS];
    logic [QUEUE_ENTRY_SIZE-1:0] r_ctx      [MAX_OUTSTANDING];
    logic [c_tag_w-1:0]          r_fifo     [MAX_OUTSTANDING];

    logic [MAX_OUTSTANDING-1:0]  r_busy;
    logic [MAX_OUTSTANDING-1:0]  r_pending;
    logic [c_tag_w:0]            r_wr_ptr;
    logic [c_tag_w:0]            r_rd_ptr;
    logic                        r_req_valid;
    logic [63:0]                 r_req_addr;
    logic [7:0]                  r_req_len;
    logic [29:0]                 r_req_dbuff;
    logic [c_tag_w-1:0]          r_req_tag;
    logic [15:0]                 r_err;

    logic                        w_free_any;
    logic [c_tag_w-1:0]          w_free_tag;
    logic                        w_s_ready;
    logic                        w_s_fire;
    logic                        w_bad;
    logic                        w_issue;
    logic                        w_drop;
    logic                        w_fifo_empty;
    logic [c_tag_w-1:0]          w_head_tag;
    logic                        w_pop;
    logic                        w_cpl_hit;
    logic                        w_stray;
    logic [1:0]                  w_err_inc;
    logic [16:0]                 w_err_sum;

    assign w_in_rpc   = bus.S_AXIS_TDATA[15:0];
    assign w_in_dbuff = bus.S_AXIS_TDATA[25:16];
    assign w_in_off   = bus.S_AXIS_TDATA[45:26];
    assign w_in_len   = bus.S_AXIS_TDATA[65:46];

    // rpc_id values at or above MAX_RPCS alias onto the low table index bits
    assign w_base     = r_addr_tbl[w_in_rpc[c_rpc_w-1:0]];

    assign w_remain   = w_in_len - w_in_off;
    assign w_blk_len  = (w_remain >= 20'(CACHE_BLOCK_SIZE)) ? 8'(CACHE_BLOCK_SIZE)
                                                            : w_remain[7:0];
    assign w_end_off  = w_in_off + {12'd0, w_blk_len};

    // Lowest-numbered free tag
    always_comb begin
        w_free_any = 1'b0;
        w_free_tag = '0;
        for (int i = MAX_OUTSTANDING - 1; i >= 0; i--) begin
            if (!r_busy[i]) begin
                w_free_any = 1'b1;
                w_free_tag = c_tag_w'(i);
            end
        end
    end

    assign w_s_ready = !ap_rst && w_free_any && (!r_req_valid || bus.dma_req_ready);
    assign w_s_fire  = bus.S_AXIS_TVALID && w_s_ready;
    assign w_bad     = (w_in_off >= w_in_len);
    assign w_issue   = w_s_fire && !w_bad;
    assign w_drop    = w_s_fire && w_bad;

    assign w_fifo_empty = (r_wr_ptr == r_rd_ptr);
    assign w_head_tag   = r_fifo[r_rd_ptr[c_tag_w-1:0]];
    assign w_pop        = !w_fifo_empty && bus.M_AXIS_TREADY;

    // A tag already queued for update is no longer awaiting data, so a repeat
    // completion on it is treated as stray rather than queued twice.
    assign w_cpl_hit = bus.dma_cpl_valid && r_pending[bus.dma_cpl_tag];
    assign w_stray   = bus.dma_cpl_valid && !w_cpl_hit;

    assign w_err_inc = {1'b0, w_drop} + {1'b0, w_stray};
    assign w_err_sum = {1'b0, r_err} + {15'd0, w_err_inc};

    always_ff @(posedge ap_clk) begin
        if (cfg_we) begin
            r_addr_tbl[cfg_rpc_id] <= cfg_addr;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (w_issue) begin
            r_ctx[w_free_tag] <= {w_in_len, w_end_off, w_in_dbuff, w_in_rpc};
            r_req_addr        <= w_base + {44'd0, w_in_off};
            r_req_len         <= w_blk_len;
            r_req_dbuff       <= {w_in_dbuff, w_in_off};
            r_req_tag         <= w_free_tag;
        end
        if (w_cpl_hit) begin
            r_fifo[r_wr_ptr[c_tag_w-1:0]] <= bus.dma_cpl_tag;
        end
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_busy      <= '0;
            r_pending   <= '0;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_req_valid <= 1'b0;
            r_err       <= '0;
        end else begin
            if (w_issue) begin
                r_busy[w_free_tag]    <= 1'b1;
                r_pending[w_free_tag] <= 1'b1;
            end
            if (w_cpl_hit) begin
                r_pending[bus.dma_cpl_tag] <= 1'b0;
                r_wr_ptr                   <= r_wr_ptr + 1'b1;
            end
            // The tag stays reserved until its update leaves, bounding FIFO fill
            if (w_pop) begin
                r_busy[w_head_tag] <= 1'b0;
                r_rd_ptr           <= r_rd_ptr + 1'b1;
            end
            if (w_issue) begin
                r_req_valid <= 1'b1;
            end else if (bus.dma_req_ready) begin
                r_req_valid <= 1'b0;
            end
            r_err <= w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];
        end
    end

    assign bus.S_AXIS_TREADY = w_s_ready;
    assign bus.M_AXIS_TVALID = !w_fifo_empty;
    assign bus.M_AXIS_TDATA  = r_ctx[w_head_tag];
    assign bus.dma_req_valid = r_req_valid;
    assign bus.dma_req_addr  = r_req_addr;
    assign bus.dma_req_len   = r_req_len;
    assign bus.dma_req_dbuff = r_req_dbuff;
    assign bus.dma_req_tag   = r_req_tag;
    assign err_count         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_srpt_fetch_dma_issuer.sv
`default_nettype none
// ============================================================================
// Module   : tb_srpt_fetch_dma_issuer
// Brief    : Randomized scoreboard bench for srpt_fetch_dma_issuer.
// Revision : 1.0 - initial release
// ============================================================================
module tb_srpt_fetch_dma_issuer;
    logic        ap_clk = 1'b0;
    logic        ap_rst;
    logic        cfg_we;
    logic [5:0]  cfg_rpc_id;
    logic [63:0] cfg_addr;
    logic [15:0] err_count;

    srpt_fetch_dma_issuer_if #(.QUEUE_ENTRY_SIZE(66), .MAX_OUTSTANDING(8)) bus ();

    srpt_fetch_dma_issuer #(
        .MAX_RPCS(64), .MAX_OUTSTANDING(8), .CACHE_BLOCK_SIZE(64), .QUEUE_ENTRY_SIZE(66)
    ) dut (
        .ap_clk(ap_clk), .ap_rst(ap_rst), .bus(bus),
        .cfg_we(cfg_we), .cfg_rpc_id(cfg_rpc_id), .cfg_addr(cfg_addr),
        .err_count(err_count)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct packed {
        logic [63:0] addr;
        logic [7:0]  len;
        logic [29:0] dbuff;
        logic [2:0]  tag;
    } dma_t;
    typedef struct packed {
        logic [65:0] data;
        logic [2:0]  tag;
    } upd_t;
    typedef struct packed {
        logic [2:0] tag;
        int         t;
    } iss_t;
    typedef struct packed {
        logic [5:0]  idx;
        logic [63:0] addr;
    } cfg_t;

    // Reference model state
    logic [63:0] m_tbl [64];
    int          m_st  [8];      // 0 free, 1 read outstanding, 2 update queued
    logic [65:0] m_ctx [8];
    dma_t        exp_dma [$];
    upd_t        exp_upd [$];
    int          exp_err;

    int n_total = 0;
    int n_bad   = 0;
    int n_dma, n_upd, cyc_n;
    logic [19:0] last_off;

    // Environment knobs and queues
    int   dma_pct   = 100;
    int   m_pct     = 100;
    bit   auto_cpl  = 0;
    bit   pick_rand = 0;
    int   cpl_delay = 3;
    bit   cfg_rand  = 0;
    iss_t issued  [$];
    logic [2:0] man_cpl [$];
    cfg_t cfg_q   [$];

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endfunction

    function automatic bit model_idle();
        bit idle = (exp_dma.size() == 0) && (exp_upd.size() == 0);
        for (int i = 0; i < 8; i++) if (m_st[i] != 0) idle = 0;
        return idle;
    endfunction

    always @(posedge ap_clk) cyc_n <= cyc_n + 1;

    // Monitor: compares DUT outputs against the model and advances the model
    upd_t        mon_u;
    dma_t        mon_d;
    logic [65:0] mon_in;
    int          mon_rpc, mon_db, mon_off, mon_len, mon_blk, mon_tag, mon_freed;
    always @(negedge ap_clk) begin
        if (ap_rst) begin
            exp_dma.delete();
            exp_upd.delete();
            exp_err = 0;
            for (int i = 0; i < 8; i++) m_st[i] = 0;
        end else begin
            mon_freed = -1;
            chk("err_count", err_count, exp_err);
            chk("m_valid", bus.M_AXIS_TVALID, exp_upd.size() != 0);
            if (bus.M_AXIS_TVALID && bus.M_AXIS_TREADY && exp_upd.size() != 0) begin
                mon_u = exp_upd.pop_front();
                chk("upd_data", bus.M_AXIS_TDATA, mon_u.data);
                mon_freed = int'(mon_u.tag);
                n_upd++;
                last_off = bus.M_AXIS_TDATA[45:26];
            end
            chk("dma_valid", bus.dma_req_valid, exp_dma.size() != 0);
            if (bus.dma_req_valid && bus.dma_req_ready && exp_dma.size() != 0) begin
                mon_d = exp_dma.pop_front();
                chk("dma_addr", bus.dma_req_addr, mon_d.addr);
                chk("dma_len", bus.dma_req_len, mon_d.len);
                chk("dma_dbuff", bus.dma_req_dbuff, mon_d.dbuff);
                chk("dma_tag", bus.dma_req_tag, mon_d.tag);
                issued.push_back('{tag: mon_d.tag, t: cyc_n});
                n_dma++;
            end
            if (bus.dma_cpl_valid) begin
                if (m_st[bus.dma_cpl_tag] == 1) begin
                    exp_upd.push_back('{data: m_ctx[bus.dma_cpl_tag], tag: bus.dma_cpl_tag});
                    m_st[bus.dma_cpl_tag] = 2;
                end else if (exp_err < 65535) begin
                    exp_err++;
                end
            end
            if (bus.S_AXIS_TVALID && bus.S_AXIS_TREADY) begin
                mon_in  = bus.S_AXIS_TDATA;
                mon_rpc = int'(mon_in[15:0]);
                mon_db  = int'(mon_in[25:16]);
                mon_off = int'(mon_in[45:26]);
                mon_len = int'(mon_in[65:46]);
                if (mon_off >= mon_len) begin
                    if (exp_err < 65535) exp_err++;
                end else begin
                    mon_blk = (mon_len - mon_off > 64) ? 64 : mon_len - mon_off;
                    mon_tag = -1;
                    for (int i = 7; i >= 0; i--) if (m_st[i] == 0) mon_tag = i;
                    if (mon_tag < 0) begin
                        n_total++;
                        n_bad++;
                        $display("FAIL accept_when_full: request accepted with no free tag");
                    end else begin
                        m_st[mon_tag]  = 1;
                        m_ctx[mon_tag] = {20'(mon_len), 20'(mon_off + mon_blk), 10'(mon_db), 16'(mon_rpc)};
                        exp_dma.push_back('{addr: m_tbl[mon_rpc % 64] + 64'(mon_off),
                                            len: 8'(mon_blk),
                                            dbuff: {10'(mon_db), 20'(mon_off)},
                                            tag: 3'(mon_tag)});
                    end
                end
            end
            if (cfg_we) m_tbl[cfg_rpc_id] = cfg_addr;
            if (mon_freed >= 0) m_st[mon_freed] = 0;
        end
    end

    // DMA ready, update ready and config drivers
    initial begin
        bus.dma_req_ready = 1'b1;
        forever begin
            @(posedge ap_clk); #1;
            bus.dma_req_ready = (int'($urandom_range(99)) < dma_pct);
        end
    end

    initial begin
        bus.M_AXIS_TREADY = 1'b1;
        forever begin
            @(posedge ap_clk); #1;
            bus.M_AXIS_TREADY = (int'($urandom_range(99)) < m_pct);
        end
    end

    initial begin : cfg_drv
        cfg_t e;
        cfg_we = 1'b0; cfg_rpc_id = '0; cfg_addr = '0;
        forever begin
            @(posedge ap_clk); #1;
            cfg_we = 1'b0;
            if (cfg_q.size() != 0) begin
                e = cfg_q.pop_front();
                cfg_we = 1'b1; cfg_rpc_id = e.idx; cfg_addr = e.addr;
            end else if (cfg_rand && $urandom_range(3) == 0) begin
                cfg_we = 1'b1;
                cfg_rpc_id = 6'($urandom_range(7));
                cfg_addr = {$urandom, $urandom};
            end
        end
    end

    // Completion responder: manual completions first, else aged reads
    initial begin : resp
        int elig [$];
        int k;
        logic [2:0] t;
        bus.dma_cpl_valid = 1'b0; bus.dma_cpl_tag = '0;
        forever begin
            @(posedge ap_clk); #1;
            bus.dma_cpl_valid = 1'b0;
            if (man_cpl.size() != 0) begin
                t = man_cpl.pop_front();
                for (int i = 0; i < issued.size(); i++)
                    if (issued[i].tag == t) begin issued.delete(i); break; end
                bus.dma_cpl_valid = 1'b1; bus.dma_cpl_tag = t;
            end else if (auto_cpl) begin
                elig.delete();
                for (int i = 0; i < issued.size(); i++)
                    if (cyc_n - issued[i].t >= cpl_delay) elig.push_back(i);
                if (elig.size() != 0) begin
                    k = pick_rand ? elig[$urandom_range(elig.size() - 1)] : elig[0];
                    bus.dma_cpl_valid = 1'b1; bus.dma_cpl_tag = issued[k].tag;
                    issued.delete(k);
                end
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge ap_clk);
        #1;
    endtask

    task automatic wait_acc();
        int n = 0;
        @(negedge ap_clk);
        while (!bus.S_AXIS_TREADY && n <= 5000) begin
            n++;
            @(negedge ap_clk);
        end
        if (n > 5000) begin
            n_total++; n_bad++;
            $display("FAIL accept_timeout: waited %0d cycles, required <= 5000", n);
        end
        @(posedge ap_clk); #1;
        bus.S_AXIS_TVALID = 1'b0;
    endtask

    task automatic put(input int rpc, input int db, input int off, input int len);
        bus.S_AXIS_TDATA  = {20'(len), 20'(off), 10'(db), 16'(rpc)};
        bus.S_AXIS_TVALID = 1'b1;
    endtask

    task automatic send(input int rpc, input int db, input int off, input int len);
        put(rpc, db, off, len);
        wait_acc();
    endtask

    task automatic drain();
        int n = 0;
        while (!model_idle() && n <= 3000) begin
            cyc(1);
            n++;
        end
        if (n > 3000) begin
            n_total++; n_bad++;
            $display("FAIL drain_timeout: model not idle after %0d cycles", n);
        end
        cyc(2);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    logic [104:0] snap, cur;
    initial begin
        int off, len, n;
        ap_rst = 1'b1;
        bus.S_AXIS_TVALID = 1'b0;
        bus.S_AXIS_TDATA  = '0;
        cyc_n = 0; n_dma = 0; n_upd = 0; exp_err = 0; last_off = '0;
        for (int i = 0; i < 8; i++) m_st[i] = 0;
        for (int i = 0; i < 64; i++) m_tbl[i] = '0;

        repeat (3) @(posedge ap_clk);
        @(negedge ap_clk);
        chk("rst_dma_valid", bus.dma_req_valid, 0);
        chk("rst_m_valid", bus.M_AXIS_TVALID, 0);
        chk("rst_err", err_count, 0);
        chk("rst_tready", bus.S_AXIS_TREADY, 0);
        @(posedge ap_clk); #1;
        ap_rst = 1'b0;
        @(negedge ap_clk);
        chk("post_rst_tready", bus.S_AXIS_TREADY, 1);
        cyc(1);

        cfg_q.push_back('{idx: 6'd1, addr: 64'h0000_0000_1000_0000});
        for (int i = 0; i < 8; i++)
            if (i != 1) cfg_q.push_back('{idx: 6'(i), addr: {$urandom, $urandom}});
        cyc(10);

        // Whole 10000-byte message in 64-byte blocks
        auto_cpl = 1; pick_rand = 0; cpl_delay = 3;
        n_dma = 0; n_upd = 0;
        for (int k = 0; k < 157; k++) send(1, 0, k * 64, 10000);
        drain();
        chk("msg_reads", n_dma, 157);
        chk("msg_updates", n_upd, 157);
        chk("msg_final_off", last_off, 10000);

        // Command register held by a stalled DMA engine
        dma_pct = 0;
        cyc(1);
        send(2, 5, 0, 300);
        put(2, 6, 64, 300);
        @(negedge ap_clk);
        snap = {bus.dma_req_addr, bus.dma_req_len, bus.dma_req_dbuff, bus.dma_req_tag};
        for (int i = 0; i < 20; i++) begin
            @(negedge ap_clk);
            cur = {bus.dma_req_addr, bus.dma_req_len, bus.dma_req_dbuff, bus.dma_req_tag};
            chk("stall_hold", cur, snap);
            chk("stall_tready", bus.S_AXIS_TREADY, 0);
        end
        dma_pct = 100;
        @(posedge ap_clk); #1;
        wait_acc();
        drain();

        // All tags busy, then free tag 3 and see it reused
        auto_cpl = 0;
        for (int i = 0; i < 8; i++) send(3, i, 0, 64 * (i + 1));
        put(3, 9, 0, 500);
        for (int i = 0; i < 5; i++) begin
            @(negedge ap_clk);
            chk("full_tready", bus.S_AXIS_TREADY, 0);
        end
        man_cpl.push_back(3'd3);
        @(posedge ap_clk); #1;
        wait_acc();
        @(negedge ap_clk);
        chk("reuse_tag", bus.dma_req_tag, 3);
        cyc(1);
        auto_cpl = 1;
        drain();

        // Out-of-order completions held behind a stalled update consumer
        auto_cpl = 0;
        for (int i = 0; i < 3; i++) send(4, 7, i * 64, 1000);
        cyc(3);
        m_pct = 0;
        cyc(1);
        man_cpl.push_back(3'd2); man_cpl.push_back(3'd0); man_cpl.push_back(3'd1);
        cyc(3);
        for (int i = 0; i < 10; i++) begin
            @(negedge ap_clk);
            chk("hold_valid", bus.M_AXIS_TVALID, 1);
            chk("hold_head_off", bus.M_AXIS_TDATA[45:26], 192);
        end
        cyc(1);
        m_pct = 100;
        drain();

        // Malformed request and stray completion
        send(5, 1, 10000, 10000);
        @(negedge ap_clk);
        chk("err_malformed", err_count, 1);
        man_cpl.push_back(3'd5);
        cyc(3);
        @(negedge ap_clk);
        chk("err_stray", err_count, 2);
        cyc(1);

        // Randomized traffic
        cfg_rand = 1; auto_cpl = 1; pick_rand = 1; cpl_delay = 2;
        dma_pct = 70; m_pct = 70;
        for (int k = 0; k < 300; k++) begin
            len = int'($urandom_range(1, 4000));
            if ($urandom_range(9) == 0) off = len + int'($urandom_range(50));
            else                        off = int'($urandom_range(len - 1));
            send(int'($urandom_range(7)), int'($urandom_range(1023)), off, len);
            n = int'($urandom_range(2));
            if (n > 0) cyc(n);
        end
        cfg_rand = 0; dma_pct = 100; m_pct = 100;
        drain();

        // Reset with four reads outstanding
        auto_cpl = 0;
        for (int i = 0; i < 4; i++) send(6, i, i * 64, 2000);
        n = 0;
        while (issued.size() < 4 && n < 50) begin cyc(1); n++; end
        ap_rst = 1'b1;
        issued.delete(); man_cpl.delete();
        cyc(2);
        ap_rst = 1'b0;
        for (int i = 0; i < 4; i++) man_cpl.push_back(3'(i));
        cyc(6);
        @(negedge ap_clk);
        chk("rst_err_stray", err_count, 4);
        chk("rst_no_update", bus.M_AXIS_TVALID, 0);
        chk("rst_tags_free", bus.S_AXIS_TREADY, 1);
        cyc(1);
        auto_cpl = 1;
        for (int i = 0; i < 8; i++) send(7, i, 0, 100 + i);
        drain();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
`default_nettype wire
